// File: rtl/regfile_arbiter_pkg.sv
// Shared register-file types and arbiter definitions for the execution/load
// side of the datapath.
package regfile_arbiter_pkg;

    localparam int RegAddrWidth = 5;
    localparam int RegWidth     = 32;

    typedef logic [RegWidth-1:0]     Register;
    typedef logic [RegAddrWidth-1:0] RegAddr;
    typedef logic                    Signal;

    localparam Signal ENABLE  = 1'b1;
    localparam Signal DISABLE = 1'b0;

    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        CLEAR
    } ArbState;

endpackage

// File: rtl/regfile_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping modulo NUM_REQ, as a one-hot grant plus its index.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int              pos;
            logic [ID_W-1:0] pos_id;
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            pos_id = ID_W'(pos);
            if (!any && req[pos_id]) begin
                gnt[pos_id] = 1'b1;
                idx         = pos_id;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin sharing of one register file (2R/1W + clear) between NUM_REQ
// requesters, with clear sequencing and registered read responses.
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_wr,
    input  logic [NUM_REQ*RegAddrWidth-1:0]  req_rs,
    input  logic [NUM_REQ*RegAddrWidth-1:0]  req_rt,
    input  logic [NUM_REQ*RegAddrWidth-1:0]  req_rd,
    input  logic [NUM_REQ*RegWidth-1:0]      req_wdata,
    input  logic                             clr_req,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [RegWidth-1:0]              rsp_rs,
    output logic [RegWidth-1:0]              rsp_rt,
    output logic                             busy,
    output logic                             rf_reset,
    output logic                             rf_write,
    output logic [RegAddrWidth-1:0]          rf_rs,
    output logic [RegAddrWidth-1:0]          rf_rt,
    output logic [RegAddrWidth-1:0]          rf_rd,
    output logic [RegWidth-1:0]              rf_wdata,
    input  logic [RegWidth-1:0]              rf_rs_i,
    input  logic [RegWidth-1:0]              rf_rt_i
);

    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("regfile_arbiter: NUM_REQ must be in 2..MAX_REQ");
    end

    ArbState            state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    ptr_next;
    logic [ID_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_any;
    logic               grant_any;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req (req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // A clear request steals the cycle, so no access competes with it.
    assign grant_any = (state == RUN) && !clr_req && pick_any;
    assign gnt       = grant_any ? pick_gnt : '0;
    assign busy      = (state != RUN);
    assign rf_reset  = busy ? ENABLE : DISABLE;
    assign ptr_next  = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

    // Stage p0: steer the granted requester's fields onto the register file.
    always_comb begin
        rf_write = DISABLE;
        rf_rs    = '0;
        rf_rt    = '0;
        rf_rd    = '0;
        rf_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                rf_write = req_wr[i] ? ENABLE : DISABLE;
                rf_rs    = req_rs[i*RegAddrWidth +: RegAddrWidth];
                rf_rt    = req_rt[i*RegAddrWidth +: RegAddrWidth];
                rf_rd    = req_rd[i*RegAddrWidth +: RegAddrWidth];
                rf_wdata = req_wdata[i*RegWidth +: RegWidth];
            end
        end
    end

    // Stage p1: sequencing FSM, pointer and registered responses; read data
    // is captured at the same edge as the write, so it holds pre-write values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= INIT;
            rr_ptr    <= '0;
            rsp_valid <= '0;
            rsp_rs    <= '0;
            rsp_rt    <= '0;
        end else begin
            rsp_valid <= gnt;
            if (grant_any) begin
                rsp_rs <= rf_rs_i;
                rsp_rt <= rf_rt_i;
                rr_ptr <= ptr_next;
            end
            case (state)
                INIT:    state <= RUN;
                CLEAR:   state <= RUN;
                RUN:     if (clr_req) state <= CLEAR;
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register-file and
// arbitration model checked every cycle, plus literal expectations.
module tb_regfile_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_wr;
    logic [NREQ*AW-1:0]    req_rs;
    logic [NREQ*AW-1:0]    req_rt;
    logic [NREQ*AW-1:0]    req_rd;
    logic [NREQ*DW-1:0]    req_wdata;
    logic                  clr_req;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rsp_valid;
    logic [DW-1:0]         rsp_rs;
    logic [DW-1:0]         rsp_rt;
    logic                  busy;
    logic                  rf_reset;
    logic                  rf_write;
    logic [AW-1:0]         rf_rs;
    logic [AW-1:0]         rf_rt;
    logic [AW-1:0]         rf_rd;
    logic [DW-1:0]         rf_wdata;
    logic [DW-1:0]         rf_rs_i;
    logic [DW-1:0]         rf_rt_i;

    int total = 0;
    int bad   = 0;

    regfile_arbiter #(.NUM_REQ(NREQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_wr    (req_wr),
        .req_rs    (req_rs),
        .req_rt    (req_rt),
        .req_rd    (req_rd),
        .req_wdata (req_wdata),
        .clr_req   (clr_req),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_rs    (rsp_rs),
        .rsp_rt    (rsp_rt),
        .busy      (busy),
        .rf_reset  (rf_reset),
        .rf_write  (rf_write),
        .rf_rs     (rf_rs),
        .rf_rt     (rf_rt),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .rf_rs_i   (rf_rs_i),
        .rf_rt_i   (rf_rt_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment register file: synchronous clear has priority over write.
    logic [DW-1:0] rf_mem [32];
    always @(posedge clk) begin
        if (rf_reset) begin
            for (int k = 0; k < 32; k++) rf_mem[k] <= '0;
        end else if (rf_write) begin
            rf_mem[rf_rd] <= rf_wdata;
        end
    end
    assign rf_rs_i = rf_mem[rf_rs];
    assign rf_rt_i = rf_mem[rf_rt];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Winner = requesting index with the smallest forward distance from ptr.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        int best  = -1;
        int bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (r[i]) begin
                int d = (i - p + NREQ) % NREQ;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    // Model: 0 = initialising, 1 = running, 2 = clearing.
    int            m_state = 0;
    int            m_ptr   = 0;
    logic [NREQ-1:0] e_vld = '0;
    logic [DW-1:0] e_rs    = '0;
    logic [DW-1:0] e_rt    = '0;
    logic [DW-1:0] m_rf [32];

    initial begin
        int            w;
        logic [NREQ-1:0] eg;
        logic [AW-1:0] ers, ert, erd;
        logic [DW-1:0] ewd;
        logic          ewr;
        for (int k = 0; k < 32; k++) m_rf[k] = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_state = 0;
                m_ptr   = 0;
                e_vld   = '0;
                e_rs    = '0;
                e_rt    = '0;
            end
            w = -1;
            if (m_state == 1 && !clr_req) w = pick(req, m_ptr);
            eg = '0; ers = '0; ert = '0; erd = '0; ewd = '0; ewr = 1'b0;
            if (w >= 0) begin
                eg[w] = 1'b1;
                ers   = req_rs[w*AW +: AW];
                ert   = req_rt[w*AW +: AW];
                erd   = req_rd[w*AW +: AW];
                ewd   = req_wdata[w*DW +: DW];
                ewr   = req_wr[w];
            end
            check("m_gnt",      32'(gnt),       32'(eg));
            check("m_busy",     32'(busy),      32'(m_state != 1));
            check("m_rf_reset", 32'(rf_reset),  32'(m_state != 1));
            check("m_rf_write", 32'(rf_write),  32'(ewr));
            check("m_rf_rs",    32'(rf_rs),     32'(ers));
            check("m_rf_rt",    32'(rf_rt),     32'(ert));
            check("m_rf_rd",    32'(rf_rd),     32'(erd));
            check("m_rf_wdata", rf_wdata,       ewd);
            check("m_rsp_vld",  32'(rsp_valid), 32'(e_vld));
            check("m_rsp_rs",   rsp_rs,         e_rs);
            check("m_rsp_rt",   rsp_rt,         e_rt);
            if (m_state != 1) begin
                for (int k = 0; k < 32; k++) m_rf[k] = '0;
                e_vld = '0;
                if (reset) m_state = 1;
            end else if (clr_req) begin
                m_state = 2;
                e_vld   = '0;
            end else if (w >= 0) begin
                e_vld = eg;
                e_rs  = m_rf[ers];
                e_rt  = m_rf[ert];
                if (ewr) m_rf[erd] = ewd;
                m_ptr = (w + 1) % NREQ;
            end else begin
                e_vld = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int i, input logic wr, input logic [AW-1:0] rs,
                              input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                              input logic [DW-1:0] wd);
        req_wr[i]             = wr;
        req_rs[i*AW +: AW]    = rs;
        req_rt[i*AW +: AW]    = rt;
        req_rd[i*AW +: AW]    = rd;
        req_wdata[i*DW +: DW] = wd;
    endtask

    // Issue one access, wait for its grant, drop it; returns in the response cycle.
    task automatic access(input int i, input logic wr, input logic [AW-1:0] rs,
                          input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                          input logic [DW-1:0] wd);
        bit ok = 0;
        set_fields(i, wr, rs, rt, rd, wd);
        req[i] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (gnt[i]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("grant_timeout", 32'(gnt), 32'(1 << i));
        tick();
        req[i]    = 1'b0;
        req_wr[i] = 1'b0;
    endtask

    logic [NREQ-1:0] rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    initial begin
        req = '0; req_wr = '0; req_rs = '0; req_rt = '0; req_rd = '0;
        req_wdata = '0; clr_req = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        tick(); tick(); tick();

        // Reset release with a read of r7 already pending.
        set_fields(0, 1'b0, 5'd7, 5'd7, 5'd0, 32'h0);
        req[0] = 1'b1;
        reset  = 1'b1;
        @(negedge clk);
        check("init_rf_reset", 32'(rf_reset), 32'd1);
        check("init_busy",     32'(busy),     32'd1);
        check("init_gnt",      32'(gnt),      32'd0);
        tick();
        @(negedge clk);
        check("run_busy", 32'(busy), 32'd0);
        check("run_gnt",  32'(gnt),  32'b001);
        tick();
        req[0] = 1'b0;
        check("r7_vld", 32'(rsp_valid), 32'b001);
        check("r7_rs",  rsp_rs,         32'h0);

        // Write then back-to-back read from another requester.
        access(0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);
        access(1, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0);
        check("b2b_vld", 32'(rsp_valid), 32'b010);
        check("b2b_rs",  rsp_rs,         32'hDEADBEEF);
        check("b2b_rt",  rsp_rt,         32'h0);
        access(2, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);

        // All requesting: strict rotation, responses one cycle behind.
        set_fields(0, 1'b0, 5'd5, 5'd1, 5'd0, 32'h0);
        set_fields(1, 1'b0, 5'd2, 5'd5, 5'd0, 32'h0);
        set_fields(2, 1'b0, 5'd3, 5'd4, 5'd0, 32'h0);
        req = 3'b111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_gnt", 32'(gnt), 32'(rr_exp[k]));
            tick();
            check("rr_vld", 32'(rsp_valid), 32'(rr_exp[k]));
        end
        req = '0;

        // Same-grant write and read returns the old value.
        access(0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h22);
        access(0, 1'b1, 5'd3, 5'd0, 5'd3, 32'h11);
        check("raw_old", rsp_rs, 32'h22);
        access(0, 1'b0, 5'd3, 5'd0, 5'd0, 32'h0);
        check("raw_new", rsp_rs, 32'h11);

        // Clear in the middle of continuous traffic (pointer starts at 1).
        set_fields(0, 1'b1, 5'd10, 5'd11, 5'd10, 32'hA0);
        set_fields(1, 1'b1, 5'd11, 5'd12, 5'd11, 32'hA1);
        set_fields(2, 1'b1, 5'd12, 5'd10, 5'd12, 32'hA2);
        req = 3'b111;
        @(negedge clk);
        check("clr_gnt_a", 32'(gnt), 32'b010);
        tick();
        @(negedge clk);
        check("clr_gnt_b", 32'(gnt), 32'b100);
        tick();
        clr_req = 1'b1;
        @(negedge clk);
        check("clr_gnt_c", 32'(gnt), 32'b000);
        tick();
        clr_req = 1'b0;
        req_wr  = '0;
        @(negedge clk);
        check("clr_gnt_d",   32'(gnt),      32'b000);
        check("clr_rfreset", 32'(rf_reset), 32'd1);
        tick();
        @(negedge clk);
        check("clr_gnt_e", 32'(gnt), 32'b001);
        tick();
        check("clr_rt_r11", rsp_rt, 32'h0);
        @(negedge clk);
        check("clr_gnt_f", 32'(gnt), 32'b010);
        tick();
        req = '0;
        check("clr_rs_r11", rsp_rs, 32'h0);
        for (int r = 0; r < 32; r++) begin
            access(0, 1'b0, AW'(r), AW'(31 - r), 5'd0, 32'h0);
            check("clr_all_rs", rsp_rs, 32'h0);
            check("clr_all_rt", rsp_rt, 32'h0);
        end

        // Asynchronous reset while a response is being presented.
        access(0, 1'b1, 5'd0, 5'd0, 5'd4, 32'h55);
        access(0, 1'b0, 5'd4, 5'd4, 5'd0, 32'h0);
        check("pre_rst_vld", 32'(rsp_valid), 32'b001);
        check("pre_rst_rs",  rsp_rs,         32'h55);
        #2 reset = 1'b0;
        #1;
        check("rst_vld", 32'(rsp_valid), 32'd0);
        check("rst_rs",  rsp_rs,         32'h0);
        check("rst_rt",  rsp_rt,         32'h0);
        tick(); tick();
        reset = 1'b1;
        @(negedge clk);
        check("reinit_rf_reset", 32'(rf_reset), 32'd1);
        check("reinit_busy",     32'(busy),     32'd1);
        tick();
        @(negedge clk);
        check("rerun_busy", 32'(busy), 32'd0);
        tick();
        access(0, 1'b0, 5'd4, 5'd4, 5'd0, 32'h0);
        check("reinit_r4", rsp_rs, 32'h0);

        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares one register file, with its two read ports, one write port and synchronous clear, between NUM_REQ requesters using round-robin arbitration.
- Sequences the register file clear after reset and on demand.
- Returns registered read data one cycle after grant.
- Sits between the execution/load units and the register file instance.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), requester index width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  NUM_REQ  per-requester request, held until granted
req_wr  input  NUM_REQ  1 = write rd, 0 = read only
req_rs  input  NUM_REQ x RegAddrWidth  read address A per requester
req_rt  input  NUM_REQ x RegAddrWidth  read address B per requester
req_rd  input  NUM_REQ x RegAddrWidth  write address per requester
req_wdata  input  NUM_REQ x Register  write data per requester
clr_req  input  1  pulse: clear entire register file
gnt  output  NUM_REQ  one-hot grant, combinational from state/pointer/req
rsp_valid  output  NUM_REQ  one-hot, registered, 1 cycle after gnt
rsp_rs  output  Register  registered read data for rs
rsp_rt  output  Register  registered read data for rt
busy  output  1  high in INIT or CLEAR
rf_reset  output  Signal  to register file clear input
rf_write  output  Signal  to register file write enable
rf_rs, rf_rt, rf_rd  output  RegAddrWidth  register file addresses
rf_wdata  output  Register  register file write data
rf_rs_i, rf_rt_i  input  Register  register file read data (combinational)

Behaviour:
- FSM states: INIT, RUN, CLEAR. Async reset (reset=0) forces INIT, rr_ptr=0, rsp_valid=0, rsp_rs=rsp_rt=0.
- INIT: rf_reset=ENABLE for exactly one cycle, gnt=0, busy=1, then RUN.
- RUN:
  - If clr_req=1, go to CLEAR. No grant that cycle.
  - Else grant the first req[i] with i searched from rr_ptr upward, wrapping modulo NUM_REQ.
  - On grant: rr_ptr <= (i+1) mod NUM_REQ. With no req, rr_ptr holds.
- CLEAR: identical to INIT (one cycle of rf_reset, busy=1, gnt=0), then RUN. clr_req is ignored while in INIT or CLEAR.
- Granted cycle:
  - rf_rs/rf_rt/rf_rd/rf_wdata are muxed from requester i.
  - rf_write=ENABLE iff req_wr[i].
  - Cycle N+1: rsp_valid[i]=1, rsp_rs/rsp_rt hold the values read in cycle N. A write in cycle N does not affect its own returned data (pre-write values).
- No grant: rf_write=DISABLE, addresses/wdata 0, rsp_valid=0 next cycle, rsp_rs/rsp_rt hold their last values.
- Handshake:
  - Requester holds req and all fields stable until gnt sampled high.
  - Keeping req high after gnt is a new request.
  - Throughput: 1 access/cycle; max wait NUM_REQ-1 cycles with all requesting.
- Back-to-back hazard: a write granted in cycle N is visible to any read granted in cycle N+1.
- rf_reset and rf_write are never ENABLE in the same cycle.
- Async reset mid-access: the pending response is dropped (rsp_valid=0). Restart via INIT clears the register file.
- Out-of-range requester index cannot occur; rr_ptr wraps explicitly at NUM_REQ-1.

Decomposition:
- Shared package definitions:
  - existing: Register, RegAddr, RegAddrWidth, Signal, ENABLE/DISABLE
  - add: ArbState enum {INIT, RUN, CLEAR}, MAX_REQ=8
- Sub-module rr_picker: combinational round-robin select (req vector, ptr -> one-hot grant, index, any). It is reusable by other arbiters.
- The top-level module holds the FSM, pointer, muxes and response registers.

Test Plan:
- Reset release -> rf_reset high exactly cycle 1, busy=1, gnt=0. Cycle 2 busy=0. A read of r7 then returns 0.
- req0 writes r5=0xDEADBEEF; next cycle req1 reads rs=r5, rt=r0 -> rsp_valid=3'b010, rsp_rs=0xDEADBEEF, rsp_rt=0.
- req=3'b111 held 6 cycles -> gnt sequence 001,010,100,001,010,100. rsp_valid mirrors it one cycle later.
- req0 writes r3=0x11 and reads rs=r3 in the same grant, r3 previously 0x22 -> rsp_rs=0x22. A following read returns 0x11.
- clr_req pulsed during continuous traffic -> one cycle with gnt=0 and rf_reset=ENABLE, then round-robin resumes from the unchanged rr_ptr. All registers then read 0.
- reset asserted low mid-cycle after a grant -> rsp_valid, rsp_rs and rsp_rt go 0 immediately (async). INIT repeats on release.
